period_counter_bank: RTL and testbench

- Bank of CH independent programmable counters.
- Each channel has a runtime-loadable period, a wrap or one-shot mode, and a one-cycle terminal-count pulse.
- Serves as the common timing source for game logic: ball step rate, paddle sampling, serve delay, score flash.
- Replaces single fixed-period counters with one configurable block.

---
 rtl/pcb_pkg.sv | 6 +
 rtl/period_counter_ch.sv | 74 +++++++
 rtl/period_counter_bank.sv | 54 +++++
 tb/tb_period_counter_bank.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pcb_pkg.sv
// pcb_pkg: shared types and defaults for the period counter bank
package pcb_pkg;
  typedef enum logic {WRAP = 1'b0, ONESHOT = 1'b1} mode_e;
  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_e;
  localparam int PCB_W = 9;
endpackage

// File: rtl/period_counter_ch.sv
// period_counter_ch: one programmable wrap/one-shot counter channel with terminal-count pulse
module period_counter_ch
  import pcb_pkg::*;
#(
  parameter int W          = PCB_W,
  parameter int DEF_PERIOD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_wr,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_mode,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         busy
);
  logic [W-1:0] period_q, period_d, cnt_q, cnt_d, last;
  mode_e        mode_q, mode_d;
  state_e       state_q, state_d;
  logic         tc_q, tc_d, busy_q, busy_d;
  // next-state: cfg write beats clr beats advance; a zero period behaves as one
  always_comb begin
    period_d = period_q;
    mode_d   = mode_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    tc_d     = 1'b0;
    busy_d   = busy_q;
    last     = (period_q == '0) ? '0 : period_q - 1'b1;
    if (cfg_wr) begin
      period_d = cfg_period;
      mode_d   = mode_e'(cfg_mode);
      state_d  = RUN;
      cnt_d    = '0;
      busy_d   = cfg_mode;
    end else if (clr) begin
      state_d = RUN;
      cnt_d   = '0;
      busy_d  = (mode_q == ONESHOT);
    end else if (adv && state_q == RUN) begin
      if (cnt_q == last) begin
        tc_d = 1'b1;
        if (mode_q == WRAP) cnt_d = '0;
        else begin
          state_d = DONE;
          busy_d  = 1'b0;
        end
      end else cnt_d = cnt_q + 1'b1;
    end
  end
  // channel registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q <= W'(DEF_PERIOD);
      mode_q   <= WRAP;
      state_q  <= RUN;
      cnt_q    <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      mode_q   <= mode_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end
  assign cnt  = cnt_q;
  assign tc   = tc_q;
  assign busy = busy_q;
endmodule

// File: rtl/period_counter_bank.sv
// period_counter_bank: CH independent period counters; PCB_PRESCALE_EN gates advancing with a shared prescaler strobe
module period_counter_bank
  import pcb_pkg::*;
#(
  parameter int CH         = 4,
  parameter int W          = PCB_W,
  parameter int DEF_PERIOD = 1,
  parameter int PRESCALE   = 16,
  localparam int CW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_period,
  input  logic          cfg_mode,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] clr,
  output logic [CH*W-1:0] cnt_out,
  output logic [CH-1:0] tc_pulse,
  output logic [CH-1:0] busy
);
  logic strobe;
`ifdef PCB_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre_q, pre_d;
  // free-running divider; strobe on the last count of each PRESCALE-cycle window
  always_comb begin
    strobe = (pre_q == PW'(PRESCALE - 1));
    pre_d  = strobe ? '0 : pre_q + 1'b1;
  end
  // prescaler register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) pre_q <= '0;
    else pre_q <= pre_d;
  end
`else
  assign strobe = 1'b1;
`endif
  for (genvar g = 0; g < CH; g++) begin : g_ch
    period_counter_ch #(.W(W), .DEF_PERIOD(DEF_PERIOD)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_wr     (cfg_we && cfg_ch == CW'(g)),
      .cfg_period (cfg_period),
      .cfg_mode   (cfg_mode),
      .clr        (clr[g]),
      .adv        (en[g] && strobe),
      .cnt        (cnt_out[g*W +: W]),
      .tc         (tc_pulse[g]),
      .busy       (busy[g])
    );
  end
endmodule

// File: tb/tb_period_counter_bank.sv
// tb_period_counter_bank: table-driven directed check of the period counter bank
module tb_period_counter_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [8:0]  cfg_period = '0;
  logic        cfg_mode = 1'b0;
  logic [3:0]  en = '0, clr = '0;
  logic [35:0] cnt_out;
  logic [3:0]  tc_pulse, busy;
  logic        cfg_we2 = 1'b0;
  logic [1:0]  cfg_ch2 = '0;
  logic [2:0]  en2 = '0, clr2 = '0;
  logic [26:0] cnt_out2;
  logic [2:0]  tc2, busy2;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  period_counter_bank #(.CH(4), .W(9), .DEF_PERIOD(1), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_mode(cfg_mode), .en(en), .clr(clr), .cnt_out(cnt_out), .tc_pulse(tc_pulse), .busy(busy));

  period_counter_bank #(.CH(3), .W(9), .DEF_PERIOD(1), .PRESCALE(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2), .cfg_period(cfg_period),
    .cfg_mode(cfg_mode), .en(en2), .clr(clr2), .cnt_out(cnt_out2), .tc_pulse(tc2), .busy(busy2));

  typedef struct {
    logic             rst;
    logic             we;
    logic [1:0]       ch;
    logic [8:0]       per;
    logic             md;
    logic [3:0]       en;
    logic [3:0]       clr;
    logic [3:0][8:0]  cnt;
    logic [3:0]       tc;
    logic [3:0]       busy;
  } vec_t;
  vec_t vq[$];

  task automatic add(input int r, we, ch, per, md, e, c, c3, c2, c1, c0, t, b);
    vec_t v;
    v.rst = 1'(r); v.we = 1'(we); v.ch = 2'(ch); v.per = 9'(per); v.md = 1'(md);
    v.en = 4'(e); v.clr = 4'(c);
    v.cnt = {9'(c3), 9'(c2), 9'(c1), 9'(c0)};
    v.tc = 4'(t); v.busy = 4'(b);
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifndef PCB_PRESCALE_EN
    //    rst we ch per md en   clr  c3 c2 c1 c0 tc   busy
    add(1, 0, 0, 0, 0, 'hF, 0,  0, 0, 0, 0, 0,   0);
    add(0, 0, 0, 0, 0, 'hF, 0,  0, 0, 0, 0, 'hF, 0);
    add(0, 0, 0, 0, 0, 'hF, 0,  0, 0, 0, 0, 'hF, 0);
    add(0, 1, 0, 5, 0, 'hF, 0,  0, 0, 0, 0, 'hE, 0);
    add(0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 1, 0,   0);
    add(0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 2, 0,   0);
    add(0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 3, 0,   0);
    add(0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 4, 0,   0);
    add(0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 0, 1,   0);
    add(0, 0, 0, 0, 0, 1,   0,  0, 0, 0, 1, 0,   0);
    add(0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 1, 0,   0);
    add(0, 1, 1, 3, 1, 3,   0,  0, 0, 0, 2, 0,   2);
    add(0, 0, 0, 0, 0, 3,   0,  0, 0, 1, 3, 0,   2);
    add(0, 0, 0, 0, 0, 3,   0,  0, 0, 2, 4, 0,   2);
    add(0, 0, 0, 0, 0, 3,   0,  0, 0, 2, 0, 3,   0);
    add(0, 0, 0, 0, 0, 2,   0,  0, 0, 2, 0, 0,   0);
    add(0, 0, 0, 0, 0, 2,   0,  0, 0, 2, 0, 0,   0);
    add(0, 0, 0, 0, 0, 2,   2,  0, 0, 0, 0, 0,   2);
    add(0, 0, 0, 0, 0, 2,   0,  0, 0, 1, 0, 0,   2);
    add(0, 0, 0, 0, 0, 2,   0,  0, 0, 2, 0, 0,   2);
    add(0, 0, 0, 0, 0, 2,   0,  0, 0, 2, 0, 2,   0);
    add(0, 1, 2, 10, 0, 4,  0,  0, 0, 2, 0, 0,   0);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 4, 0, 0, k, 2, 0, 0, 0);
    add(0, 1, 2, 4, 0, 4,   4,  0, 0, 2, 0, 0,   0);
    add(0, 0, 0, 0, 0, 4,   0,  0, 1, 2, 0, 0,   0);
    add(0, 0, 0, 0, 0, 4,   0,  0, 2, 2, 0, 0,   0);
    add(0, 0, 0, 0, 0, 4,   0,  0, 3, 2, 0, 0,   0);
    add(0, 0, 0, 0, 0, 4,   0,  0, 0, 2, 0, 4,   0);
    add(0, 1, 3, 0, 0, 8,   0,  0, 0, 2, 0, 0,   0);
    add(0, 0, 0, 0, 0, 8,   0,  0, 0, 2, 0, 8,   0);
    add(0, 0, 0, 0, 0, 8,   0,  0, 0, 2, 0, 8,   0);
    add(0, 0, 0, 0, 0, 'hD, 2,  0, 1, 0, 1, 8,   2);
    add(0, 1, 0, 1, 1, 1,   0,  0, 1, 0, 0, 0,   3);
    add(0, 0, 0, 0, 0, 1,   0,  0, 1, 0, 0, 1,   2);
    add(0, 0, 0, 0, 0, 1,   0,  0, 1, 0, 0, 0,   2);
    foreach (vq[i]) begin
      rst_n = !vq[i].rst; cfg_we = vq[i].we; cfg_ch = vq[i].ch; cfg_period = vq[i].per;
      cfg_mode = vq[i].md; en = vq[i].en; clr = vq[i].clr;
      step();
      check($sformatf("v%0d cnt", i), cnt_out, vq[i].cnt);
      check($sformatf("v%0d tc", i), tc_pulse, vq[i].tc);
      check($sformatf("v%0d busy", i), busy, vq[i].busy);
    end
    cfg_we = 0; en = 0; clr = 0;
    cfg_we2 = 1; cfg_ch2 = 3; cfg_period = 2; cfg_mode = 1; en2 = 0;
    step();
    check("oor busy", busy2, 3'b000);
    check("oor cnt", cnt_out2, 27'd0);
    cfg_we2 = 0; en2 = 3'b111;
    step();
    check("oor tc1", tc2, 3'b111);
    step();
    check("oor tc2", tc2, 3'b111);
    check("oor cnt2", cnt_out2, 27'd0);
`else
    rst_n = 0; en = 0;
    repeat (2) step();
    check("pre reset cnt", cnt_out, 36'd0);
    rst_n = 1; cfg_we = 1; cfg_ch = 0; cfg_period = 2; cfg_mode = 0; en = 4'b0001;
    step();
    cfg_we = 0;
    check("pre k1 cnt", cnt_out[8:0], 9'd0);
    for (int k = 2; k <= 12; k++) begin
      step();
      check($sformatf("pre k%0d cnt", k), cnt_out[8:0], (k >= 4) ? 36'((k / 4) % 2) : 36'd0);
      check($sformatf("pre k%0d tc", k), tc_pulse[0], (k % 8 == 0) ? 36'd1 : 36'd0);
    end
    clr = 4'b0001;
    step();
    check("pre clr cnt", cnt_out[8:0], 9'd0);
    clr = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
